// File: rtl/seven_segment_scanner.sv
// Time-multiplexed hex display driver: frame-synchronous shadow, LZS, blank/DP, blink.
// segment/digit_select update one cycle after each slot tick; no backpressure, load is never refused.
module seven_segment_scanner #(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_mask,
    input  logic [DIGITS-1:0]   blank_mask,
    input  logic                lzs,
    input  logic                blink,
    output logic                busy,
    output logic                load_ack,
    output logic [7:0]          segment,
    output logic [DIGITS-1:0]   digit_select
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]            presc;
    logic [IW-1:0]            idx;
    logic [FW-1:0]            frame_cnt;
    logic                     phase;

    logic [DIGITS-1:0][3:0]   pend_val;
    logic [DIGITS-1:0]        pend_dp;
    logic [DIGITS-1:0]        pend_blank;
    logic [DIGITS-1:0][3:0]   disp_val;
    logic [DIGITS-1:0]        disp_dp;
    logic [DIGITS-1:0]        disp_blank;

    logic                     tick;
    logic                     frame_end;
    logic                     take;
    logic [DIGITS-1:0]        lead_zero;
    logic                     run;
    logic [3:0]               cur_nib;
    logic [7:0]               seg_next;
    logic [DIGITS-1:0]        sel_next;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hF6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h1A;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign tick      = (presc == PW'(PRESCALE - 1));
    assign frame_end = tick && (idx == IW'(DIGITS - 1));
    // A load landing on the boundary cycle is shown straight away rather than waiting a frame.
    assign take      = frame_end && (busy || load);

    // lead_zero[i]: digit i and every digit above it are zero
    always_comb begin
        lead_zero = '0;
        run       = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run          = run & (disp_val[i] == 4'h0);
            lead_zero[i] = run;
        end
    end

    always_comb begin
        cur_nib       = disp_val[idx];
        sel_next      = '0;
        sel_next[idx] = 1'b1;
        seg_next      = seg_decode(cur_nib) | {7'b0, disp_dp[idx]};
        if (disp_blank[idx] || (lzs && (idx != '0) && lead_zero[idx]) || (blink && phase))
            seg_next = 8'h00;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc        <= '0;
            idx          <= '0;
            frame_cnt    <= '0;
            phase        <= 1'b0;
            segment      <= 8'h00;
            digit_select <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                idx          <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
                segment      <= seg_next;
                digit_select <= sel_next;
            end
            if (frame_end) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            busy       <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            load_ack <= take;
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_mask;
                pend_blank <= blank_mask;
            end
            if (take) begin
                disp_val   <= load ? value      : pend_val;
                disp_dp    <= load ? dp_mask    : pend_dp;
                disp_blank <= load ? blank_mask : pend_blank;
                busy       <= 1'b0;
            end else if (load) begin
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomised scoreboard bench: slot/frame arithmetic reference model vs the scanner, plus a 1-digit instance.
module tb_seven_segment_scanner;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int BF = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  blank_mask = '0;
    logic        lzs = 1'b0;
    logic        blink = 1'b0;
    logic        busy;
    logic        load_ack;
    logic [7:0]  segment;
    logic [3:0]  digit_select;

    logic        load1 = 1'b0;
    logic [3:0]  value1 = '0;
    logic        busy1;
    logic        ack1;
    logic [7:0]  seg1;
    logic [0:0]  sel1;

    always #5 clock = ~clock;

    seven_segment_scanner #(.DIGITS(D), .PRESCALE(P), .BLINK_FRAMES(BF)) dut (
        .clock(clock), .reset(reset), .load(load), .value(value),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .lzs(lzs), .blink(blink),
        .busy(busy), .load_ack(load_ack), .segment(segment), .digit_select(digit_select)
    );

    seven_segment_scanner #(.DIGITS(1), .PRESCALE(1), .BLINK_FRAMES(2)) dut1 (
        .clock(clock), .reset(reset), .load(load1), .value(value1),
        .dp_mask(1'b0), .blank_mask(1'b0), .lzs(1'b0), .blink(1'b0),
        .busy(busy1), .load_ack(ack1), .segment(seg1), .digit_select(sel1)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

    // Reference model: slot s = edges since reset / P, digit = s % D, frame = s / D.
    int          n;
    int          s_m;
    logic        tick_m;
    logic        bound_m;
    logic [15:0] pend_val, disp_val;
    logic [3:0]  pend_dp, disp_dp, pend_blank, disp_blank;
    logic        busy_m = 1'b0;
    logic        ack_m = 1'b0;
    logic [11:0] exp_q [$];

    function automatic logic [7:0] model_seg(input int d, input int s);
        logic [3:0] nib;
        logic       dark;
        nib  = disp_val[4*d +: 4];
        dark = disp_blank[d] || (lzs && d > 0 && (disp_val >> (4*d)) == 16'h0);
        if (blink && (((s / D) / BF) % 2 == 1)) return 8'h00;
        if (dark) return 8'h00;
        return seg_tab[nib] | {7'b0, disp_dp[d]};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            n = 0; busy_m = 0; ack_m = 0;
            pend_val = 0; pend_dp = 0; pend_blank = 0;
            disp_val = 0; disp_dp = 0; disp_blank = 0;
            exp_q.delete();
        end else begin
            tick_m  = (n % P) == P - 1;
            s_m     = n / P;
            bound_m = tick_m && (s_m % D == D - 1);
            if (load) begin
                pend_val = value; pend_dp = dp_mask; pend_blank = blank_mask;
            end
            if (tick_m)
                exp_q.push_back({4'(1 << (s_m % D)), model_seg(s_m % D, s_m)});
            ack_m = 0;
            if (bound_m && (busy_m || load)) begin
                disp_val = pend_val; disp_dp = pend_dp; disp_blank = pend_blank;
                busy_m = 0; ack_m = 1;
            end else if (load) begin
                busy_m = 1;
            end
            n++;
        end
    end

    logic [3:0]  last_sel = '0;
    logic [11:0] e;

    always @(negedge clock) begin
        if (!reset) begin
            last_sel = '0;
            check("reset_outputs", 32'({segment, digit_select, load_ack, busy}), 32'h0);
        end else begin
            check("load_ack", 32'(load_ack), 32'(ack_m));
            check("busy", 32'(busy), 32'(busy_m));
            if (digit_select != last_sel) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_slot", 32'(digit_select), 32'(last_sel));
                end else begin
                    e = exp_q.pop_front();
                    check("digit_select", 32'(digit_select), 32'(e[11:8]));
                    check("segment", 32'(segment), 32'(e[7:0]));
                end
                last_sel = digit_select;
            end
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        value = v; dp_mask = dp; blank_mask = bl; load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic wait_phase(input int k);
        while ((n % (D*P)) != k) @(negedge clock);
    endtask

    task automatic rand_load();
        logic [15:0] v;
        v = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
        do_load(v, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] v1;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;

        @(negedge clock);
        check("u1_select", 32'(sel1), 32'h1);
        check("u1_idle_seg", 32'(seg1), 32'hFC);
        for (int k = 0; k < 4; k++) begin
            v1 = 4'($urandom_range(0, 15));
            value1 = v1; load1 = 1'b1;
            @(negedge clock);
            load1 = 1'b0;
            check("u1_ack", 32'(ack1), 32'h1);
            check("u1_busy", 32'(busy1), 32'h0);
            @(negedge clock);
            check("u1_seg", 32'(seg1), 32'(seg_tab[v1]));
            check("u1_ack_pulse", 32'(ack1), 32'h0);
            check("u1_select_hold", 32'(sel1), 32'h1);
        end

        repeat (3*D*P) @(negedge clock);

        wait_phase(6);
        do_load(16'h12AF, 4'b0010, 4'b0000);
        check("busy_after_load", 32'(busy), 32'h1);
        repeat (40) @(negedge clock);

        wait_phase(1);
        do_load(16'h1111, 4'h0, 4'h0);
        repeat (3) @(negedge clock);
        do_load(16'h2222, 4'h0, 4'h0);
        repeat (40) @(negedge clock);

        lzs = 1'b1;
        do_load(16'h0040, 4'h0, 4'h0);
        repeat (40) @(negedge clock);
        do_load(16'h0000, 4'h0, 4'h0);
        repeat (40) @(negedge clock);
        lzs = 1'b0;

        do_load(16'h8421, 4'h5, 4'h0);
        blink = 1'b1;
        repeat (6*D*P) @(negedge clock);
        while (((n / P) / D / BF) % 2 != 1) @(negedge clock);
        repeat (5) @(negedge clock);
        blink = 1'b0;
        repeat (32) @(negedge clock);

        for (int it = 0; it < 250; it++) begin
            repeat ($urandom_range(0, 20)) @(negedge clock);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rand_load();
                6: lzs = ~lzs;
                7: blink = ~blink;
                8: do_load(16'($urandom), 4'($urandom), 4'($urandom));
                default: begin
                    rand_load();
                    rand_load();
                end
            endcase
        end
        lzs = 1'b0; blink = 1'b0;
        repeat (40) @(negedge clock);

        wait_phase(3);
        do_load(16'hBEEF, 4'hF, 4'h0);
        check("busy_before_reset", 32'(busy), 32'h1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_seg", 32'(segment), 32'h0);
        check("async_sel", 32'(digit_select), 32'h0);
        check("async_busy", 32'(busy), 32'h0);
        check("async_ack", 32'(load_ack), 32'h0);
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (4*D*P) @(negedge clock);

        @(negedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
